// File: rtl/axi4_pkg.sv
// axi4_pkg: shared AXI4 response codes, master/slave FSM state types and AxSIZE helper
package axi4_pkg;
    typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
    typedef enum logic [2:0] {ST_IDLE, ST_AW, ST_W, ST_B, ST_AR, ST_R} mst_state_t;
    typedef enum logic [1:0] {SL_IDLE, SL_WDATA, SL_WRESP, SL_RDATA} slv_state_t;
    function automatic logic [2:0] axsize(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction
endpackage

// File: rtl/axi4_full_master.sv
// axi4_full_master: single-outstanding AXI4 INCR burst initiator; AXI4_MASTER_LAST_CHECK_EN enables the RLAST cross-check
module axi4_full_master
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WVALID,
    output logic                  WLAST,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  RVALID,
    input  logic                  RLAST,
    output logic                  RREADY
);
    localparam logic [2:0] SIZE = axsize(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~((ADDR_WIDTH'(1) << SIZE) - ADDR_WIDTH'(1));

    mst_state_t state, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0] len_q, beat_cnt;
    logic run_q, done_q, err_q, done_d, err_d, at_last, accept, w_hs, r_hs, r_final, r_err;

    assign at_last = beat_cnt == len_q;
    assign accept  = cmd_valid & cmd_ready;
    assign w_hs    = WVALID & WREADY;
    assign r_hs    = RVALID & RREADY;
`ifdef AXI4_MASTER_LAST_CHECK_EN
    logic lerr_q;
    assign r_final = at_last;
    assign r_err   = lerr_q | (RLAST != at_last);
`else
    assign r_final = RLAST;
    assign r_err   = 1'b0;
`endif

    assign AWADDR  = addr_q;
    assign ARADDR  = addr_q;
    assign AWLEN   = len_q;
    assign ARLEN   = len_q;
    assign AWSIZE  = SIZE;
    assign ARSIZE  = SIZE;
    assign WDATA   = wr_data;
    assign rd_data = RDATA;
    assign done    = done_q;
    assign err     = err_q;

    // State register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= ST_IDLE;
        else          state <= state_d;
    end

    // Next state and channel handshake outputs; streams pass through only in their own state
    always_comb begin
        state_d   = state;
        cmd_ready = 1'b0;
        AWVALID   = 1'b0;
        ARVALID   = 1'b0;
        WVALID    = 1'b0;
        WLAST     = 1'b0;
        wr_ready  = 1'b0;
        BREADY    = 1'b0;
        RREADY    = 1'b0;
        rd_valid  = 1'b0;
        rd_last   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = run_q & ~done_q;
                if (cmd_valid & run_q & ~done_q) state_d = cmd_write ? ST_AW : ST_AR;
            end
            ST_AW: begin
                AWVALID = 1'b1;
                if (AWREADY) state_d = ST_W;
            end
            ST_W: begin
                WVALID   = wr_valid;
                wr_ready = WREADY;
                WLAST    = at_last;
                if (wr_valid & WREADY & at_last) state_d = ST_B;
            end
            ST_B: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    done_d  = 1'b1;
                    err_d   = resp_t'(BRESP) != OKAY;
                    state_d = ST_IDLE;
                end
            end
            ST_AR: begin
                ARVALID = 1'b1;
                if (ARREADY) state_d = ST_R;
            end
            ST_R: begin
                rd_valid = RVALID;
                RREADY   = rd_ready;
                rd_last  = at_last;
                if (RVALID & rd_ready & r_final) begin
                    done_d  = 1'b1;
                    err_d   = r_err;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command latch, saturating beat counter, and registered completion pulse
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            run_q    <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            run_q  <= 1'b1;
            done_q <= done_d;
            err_q  <= err_d;
            if (accept) begin
                addr_q   <= cmd_addr & ADDR_MASK;
                len_q    <= cmd_len;
                beat_cnt <= '0;
            end else if ((w_hs | r_hs) && !at_last) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

`ifdef AXI4_MASTER_LAST_CHECK_EN
    // Sticky RLAST/beat-count mismatch flag, cleared per command
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)                    lerr_q <= 1'b0;
        else if (accept)                 lerr_q <= 1'b0;
        else if (r_hs && RLAST != at_last) lerr_q <= 1'b1;
    end
`endif
endmodule
